// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single 64-bit memory port with fixed read latency.
// Define ARB_STATS_EN to add per-port grant counters and a stall-cycle counter.
module mem_arbiter #(
  parameter int AW     = 48,
  parameter int DW     = 64,
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic            we0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   wdata0,
  input  logic [DW/8-1:0] mask0,
  output logic            gnt0,
  output logic            rvalid0,
  input  logic            req1,
  input  logic            we1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   wdata1,
  input  logic [DW/8-1:0] mask1,
  output logic            gnt1,
  output logic            rvalid1,
  output logic [DW-1:0]   rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_mask,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]     stat_gnt0,
  output logic [31:0]     stat_gnt1,
  output logic [31:0]     stat_stall
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_lastGnt;
  logic              r_win;
  logic              r_we;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [DW/8-1:0]   r_mask;
  logic [3:0]        r_cnt;
  logic              w_any;
  logic              w_pick1;
  logic              w_selWe;

  // With both requesting, the port that did not win last time goes next.
  assign w_any   = req0 | req1;
  assign w_pick1 = req1 & (~req0 | ~r_lastGnt);
  assign w_selWe = w_pick1 ? we1 : we0;

  assign busy      = (r_state != IDLE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_mask  = r_mask;

  always_comb begin
    w_next  = r_state;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rvalid0 = 1'b0;
    rvalid1 = 1'b0;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_next = ISSUE;
      end
      ISSUE: begin
        mem_en = 1'b1;
        mem_we = r_we;
        gnt0   = ~r_win;
        gnt1   = r_win;
        w_next = r_we ? IDLE : WAIT;
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_next = RESP;
      end
      RESP: begin
        rvalid0 = ~r_win;
        rvalid1 = r_win;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lastGnt <= 1'b1;
      r_win     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_cnt     <= 4'd0;
      rdata     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win     <= w_pick1;
            r_lastGnt <= w_pick1;
            r_we      <= w_selWe;
            r_addr    <= w_pick1 ? addr1 : addr0;
            r_wdata   <= w_pick1 ? wdata1 : wdata0;
            // Reads always present a full-width mask to memory.
            r_mask    <= w_selWe ? (w_pick1 ? mask1 : mask0) : '1;
          end
        end
        ISSUE: begin
          if (!r_we) r_cnt <= 4'(RD_LAT - 1);
        end
        WAIT: begin
          if (r_cnt == 4'd0) rdata <= mem_rdata;
          else               r_cnt <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic w_stall;

  // A requester stalls while the arbiter is busy or while it loses arbitration in IDLE.
  assign w_stall = (req0 & (busy | w_pick1)) | (req1 & (busy | ~w_pick1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_gnt0  <= 32'd0;
      stat_gnt1  <= 32'd0;
      stat_stall <= 32'd0;
    end else begin
      if (gnt0)    stat_gnt0  <= stat_gnt0 + 32'd1;
      if (gnt1)    stat_gnt1  <= stat_gnt1 + 32'd1;
      if (w_stall) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner-case sequences and random pairs
// checked against a transaction-level schedule and memory model.
module tb_mem_arbiter;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [7:0]    mask0, mask1;
  logic          gnt0, rvalid0, gnt1, rvalid1;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_mask;
  logic [DW-1:0] mem_rdata;
  logic          busy;
`ifdef ARB_STATS_EN
  logic [31:0]   stat_gnt0, stat_gnt1, stat_stall;
`endif

  int checks = 0;
  int errors = 0;
  bit modelLast;
  logic [63:0] modelMem[logic [47:0]];
  logic [63:0] respMem[logic [47:0]];

  typedef struct {
    bit          act0, act1;
    bit          we0, we1;
    logic [47:0] a0, a1;
    logic [63:0] d0, d1;
    logic [7:0]  m0, m1;
    bit          expWin;
  } vec_t;

  typedef struct {
    int          due;
    logic [47:0] addr;
  } rd_t;
  rd_t rdQ[$];
  int  ncyc = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .mask0(mask0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .mask1(mask1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] memInit(input logic [47:0] a);
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
  endfunction

  function automatic logic [63:0] applyMask(input logic [63:0] old, input logic [63:0] nw,
                                            input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] modelRead(input logic [47:0] a);
    return modelMem.exists(a) ? modelMem[a] : memInit(a);
  endfunction

  function automatic logic [63:0] respRead(input logic [47:0] a);
    return respMem.exists(a) ? respMem[a] : memInit(a);
  endfunction

  // Memory responder: applies bus writes and returns read data RD_LAT cycles after mem_en.
  always @(negedge clk) begin
    ncyc++;
    while (rdQ.size() > 0 && rdQ[0].due < ncyc) void'(rdQ.pop_front());
    if (rdQ.size() > 0 && rdQ[0].due == ncyc) begin
      mem_rdata = respRead(rdQ[0].addr);
      void'(rdQ.pop_front());
    end else begin
      mem_rdata = {$urandom, $urandom};
    end
    if (mem_en === 1'b1) begin
      if (mem_we) respMem[mem_addr] = applyMask(respRead(mem_addr), mem_wdata, mem_mask);
      else        rdQ.push_back('{ncyc + RD_LAT, mem_addr});
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Presents one or two requests to an idle arbiter and checks every cycle until both complete.
  task automatic applyStimulus(input vec_t v);
    bit          act[2], we[2], eg[2], er[2], eb;
    logic [47:0] ad[2];
    logic [63:0] wd[2], expRd[2];
    logic [7:0]  mk[2];
    int          iss[2], occ[2];
    int          first, lastEnd;
    act = '{v.act0, v.act1}; we = '{v.we0, v.we1};
    ad = '{v.a0, v.a1}; wd = '{v.d0, v.d1}; mk = '{v.m0, v.m1};
    expRd = '{64'd0, 64'd0};
    req0 = v.act0; we0 = v.we0; addr0 = v.a0; wdata0 = v.d0; mask0 = v.m0;
    req1 = v.act1; we1 = v.we1; addr1 = v.a1; wdata1 = v.d1; mask1 = v.m1;
    for (int p = 0; p < 2; p++) occ[p] = we[p] ? 1 : RD_LAT + 2;
    iss = '{-100, -100};
    first = (act[0] && act[1]) ? int'(v.expWin) : (act[0] ? 0 : 1);
    iss[first] = 1;
    if (act[0] && act[1]) begin
      iss[1-first] = occ[first] + 2;
      modelLast = bit'(1 - first);
    end else begin
      modelLast = bit'(first);
    end
    lastEnd = 0;
    for (int p = 0; p < 2; p++)
      if (act[p] && iss[p] + occ[p] - 1 > lastEnd) lastEnd = iss[p] + occ[p] - 1;
    for (int k = 1; k <= lastEnd + 1; k++) begin
      @(negedge clk);
      eb = 1'b0;
      for (int p = 0; p < 2; p++) begin
        eg[p] = act[p] && (k == iss[p]);
        er[p] = act[p] && !we[p] && (k == iss[p] + RD_LAT + 1);
        if (act[p] && k >= iss[p] && k <= iss[p] + occ[p] - 1) eb = 1'b1;
      end
      checkOutput($sformatf("gnt0@%0d", k), 64'(gnt0), 64'(eg[0]));
      checkOutput($sformatf("gnt1@%0d", k), 64'(gnt1), 64'(eg[1]));
      checkOutput($sformatf("rvalid0@%0d", k), 64'(rvalid0), 64'(er[0]));
      checkOutput($sformatf("rvalid1@%0d", k), 64'(rvalid1), 64'(er[1]));
      checkOutput($sformatf("mem_en@%0d", k), 64'(mem_en), 64'(eg[0] | eg[1]));
      checkOutput($sformatf("busy@%0d", k), 64'(busy), 64'(eb));
      for (int p = 0; p < 2; p++) begin
        if (eg[p]) begin
          checkOutput($sformatf("mem_we.p%0d", p), 64'(mem_we), 64'(we[p]));
          checkOutput($sformatf("mem_addr.p%0d", p), 64'(mem_addr), 64'(ad[p]));
          checkOutput($sformatf("mem_wdata.p%0d", p), mem_wdata, wd[p]);
          checkOutput($sformatf("mem_mask.p%0d", p), 64'(mem_mask), 64'(we[p] ? mk[p] : 8'hFF));
          if (we[p]) modelMem[ad[p]] = applyMask(modelRead(ad[p]), wd[p], mk[p]);
          else       expRd[p] = modelRead(ad[p]);
          // Requester drops the request and its fields become don't-care.
          if (p == 0) begin
            req0 = 1'b0; we0 = 1'($urandom); addr0 = {16'h0, $urandom};
            wdata0 = {$urandom, $urandom}; mask0 = 8'($urandom);
          end else begin
            req1 = 1'b0; we1 = 1'($urandom); addr1 = {16'h0, $urandom};
            wdata1 = {$urandom, $urandom}; mask1 = 8'($urandom);
          end
        end
        if (er[p]) checkOutput($sformatf("rdata.p%0d", p), rdata, expRd[p]);
      end
    end
  endtask

  task automatic drainIdle();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    checkOutput("drainIdle", 64'(busy), 64'd0);
  endtask

  logic [47:0] pool[4] = '{48'h1000, 48'h2008, 48'h3000, 48'h4010};
  vec_t        tbl[8];

  initial begin
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; mask0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; mask1 = '0;
    modelMem[48'h2008] = 64'hDEADBEEFCAFEF00D;
    respMem[48'h2008]  = 64'hDEADBEEFCAFEF00D;
    repeat (3) @(negedge clk);
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.gnt", 64'({gnt0, gnt1, rvalid0, rvalid1}), 64'd0);
    checkOutput("rst.mem_en", 64'({mem_en, mem_we}), 64'd0);
    checkOutput("rst.mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst.mem_wdata", mem_wdata, 64'd0);
    checkOutput("rst.mem_mask", 64'(mem_mask), 64'd0);
    checkOutput("rst.rdata", rdata, 64'd0);
    reset = 1'b0;
    modelLast = 1'b1;

    // Both ports hold read requests continuously: grants must alternate starting with port 0.
    begin
      int got;
      int ord[4];
      got = 0;
      ord = '{9, 9, 9, 9};
      req0 = 1'b1; we0 = 1'b0; addr0 = 48'h3000;
      req1 = 1'b1; we1 = 1'b0; addr1 = 48'h4010;
      for (int k = 0; k < 60 && got < 4; k++) begin
        @(negedge clk);
        if (gnt0 === 1'b1)      begin ord[got] = 0; got++; end
        else if (gnt1 === 1'b1) begin ord[got] = 1; got++; end
      end
      req0 = 1'b0; req1 = 1'b0;
      checkOutput("contGrants", 64'(got), 64'd4);
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("contOrder%0d", i), 64'(ord[i]), 64'(i % 2));
`ifdef ARB_STATS_EN
      @(negedge clk);
      checkOutput("stat_gnt0", 64'(stat_gnt0), 64'd2);
      checkOutput("stat_gnt1", 64'(stat_gnt1), 64'd2);
`endif
      drainIdle();
      modelLast = 1'b1;
    end

    tbl[0] = '{1, 0, 1, 0, 48'h1000, 48'h0,    64'h1122334455667788, 64'h0, 8'h0F, 8'h00, 0};
    tbl[1] = '{0, 1, 0, 0, 48'h0,    48'h2008, 64'h0, 64'h0, 8'h00, 8'h00, 1};
    tbl[2] = '{1, 1, 0, 0, 48'h1000, 48'h3000, 64'h0, 64'h0, 8'h00, 8'h00, 0};
    tbl[3] = '{1, 1, 1, 1, 48'h3000, 48'h3000, 64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7, 8'hF0, 8'h0F, 0};
    tbl[4] = '{0, 1, 0, 1, 48'h0,    48'h4010, 64'h0, 64'hC0C1C2C3C4C5C6C7, 8'h00, 8'h3C, 1};
    tbl[5] = '{1, 0, 0, 0, 48'h3000, 48'h0,    64'h0, 64'h0, 8'h00, 8'h00, 0};
    tbl[6] = '{1, 1, 0, 1, 48'h4010, 48'h1000, 64'h0, 64'hD0D1D2D3D4D5D6D7, 8'h00, 8'h80, 1};
    tbl[7] = '{1, 1, 0, 0, 48'h1000, 48'h2008, 64'h0, 64'h0, 8'h00, 8'h00, 1};
    for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);

    // A one-cycle req1 pulse during a port 0 read must be ignored.
    begin
      int enCnt, g1Cnt, rv0Cnt;
      logic [63:0] e;
      enCnt = 0; g1Cnt = 0; rv0Cnt = 0;
      e = modelRead(48'h1000);
      req0 = 1'b1; we0 = 1'b0; addr0 = 48'h1000;
      for (int k = 1; k <= RD_LAT + 6; k++) begin
        @(negedge clk);
        if (mem_en === 1'b1) enCnt++;
        if (gnt1 === 1'b1) g1Cnt++;
        if (rvalid0 === 1'b1) begin
          rv0Cnt++;
          checkOutput("pulseRdata", rdata, e);
        end
        if (k == 1) req0 = 1'b0;
        if (k == 2) begin
          req1 = 1'b1; we1 = 1'b1; addr1 = 48'h5000; wdata1 = {$urandom, $urandom}; mask1 = 8'hFF;
        end
        if (k == 3) req1 = 1'b0;
      end
      checkOutput("pulseMemEn", 64'(enCnt), 64'd1);
      checkOutput("pulseGnt1", 64'(g1Cnt), 64'd0);
      checkOutput("pulseRvalid0", 64'(rv0Cnt), 64'd1);
      modelLast = 1'b0;
    end

    // Reset during WAIT aborts the read and restores port 0 priority.
    req0 = 1'b1; we0 = 1'b0; addr0 = 48'h2008;
    @(negedge clk);
    checkOutput("abortGnt0", 64'(gnt0), 64'd1);
    req0 = 1'b0;
    @(negedge clk);
    checkOutput("abortBusy", 64'(busy), 64'd1);
    reset = 1'b1;
    for (int k = 0; k < RD_LAT + 5; k++) begin
      @(negedge clk);
      if (k == 1) reset = 1'b0;
      checkOutput($sformatf("abortRvalid0@%0d", k), 64'(rvalid0), 64'd0);
      checkOutput($sformatf("abortBusy@%0d", k), 64'(busy), 64'd0);
    end
    modelLast = 1'b1;
    applyStimulus('{1, 1, 0, 0, 48'h4010, 48'h1000, 64'h0, 64'h0, 8'h00, 8'h00, 0});

    for (int i = 0; i < 40; i++) begin
      vec_t r;
      int   a;
      a = $urandom_range(1, 3);
      r.act0 = a[0]; r.act1 = a[1];
      r.we0 = 1'($urandom); r.we1 = 1'($urandom);
      r.a0 = pool[$urandom_range(0, 3)]; r.a1 = pool[$urandom_range(0, 3)];
      r.d0 = {$urandom, $urandom}; r.d1 = {$urandom, $urandom};
      r.m0 = 8'($urandom); r.m1 = 8'($urandom);
      r.expWin = (r.act0 && r.act1) ? ~modelLast : r.act1;
      applyStimulus(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 64-bit SoC memory port between two requesters.
- Port 0 is the CPU load/store/fetch path. Port 1 is an auxiliary master (DMA/video).
- Serialises one transaction at a time, with round-robin priority, a req/gnt handshake and a fixed-latency read return.
- Sits between the CPU/aux masters and the memory/MMIO decode.

Parameters:
- AW, 48, address width (byte address).
- DW, 64, data width; byte mask width is DW/8.
- RD_LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held until gnt0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  AW  port 0 byte address
- wdata0  in  DW  port 0 write data
- mask0  in  DW/8  port 0 byte-enable mask (writes)
- gnt0  out  1  one-cycle pulse: port 0 request accepted and issued
- rvalid0  out  1  one-cycle pulse: rdata valid for port 0 read
- req1, we1, addr1, wdata1, mask1, gnt1, rvalid1: same as port 0, for port 1
- rdata  out  DW  registered read data, shared by both ports and qualified by rvalidN
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_mask  out  DW/8  memory byte mask
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after mem_en
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, last_gnt=1 (port 0 wins first), latency counter 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - No req: stay in IDLE.
  - Arbitration: if only one req, that port wins. If both, the port != last_gnt wins.
  - Latch winner's we/addr/wdata/mask, update last_gnt, go to ISSUE.
- ISSUE (exactly 1 cycle)
  - mem_en=1; mem_we/addr/wdata/mask from the latch; gntN=1 for the winner.
  - mem_mask is forced to all-ones on reads.
  - Write -> IDLE. Read -> WAIT, counter loaded with RD_LAT-1.
- WAIT
  - Decrement the counter; when it reaches 0, capture mem_rdata into rdata and go to RESP.
  - If RD_LAT=1, WAIT lasts 1 cycle.
  - Result: capture happens RD_LAT cycles after the ISSUE cycle.
- RESP (1 cycle): rvalidN=1 for the granted port, rdata held stable. Then IDLE.
- Timing
  - Write: gnt in cycle T+1 after req is seen in IDLE at T; 2-cycle minimum turnaround.
  - Read: rvalid at T+RD_LAT+2; rdata held until the next read capture.
- mem_en, mem_we, gnt and rvalid are 0 outside their stated states. mem_addr/wdata/mask hold their last value.
- Requester rules
  - A requester must hold req and its fields stable until gnt.
  - Deasserting req before it is sampled in IDLE cancels it; no transaction occurs.
  - Changes after latching are ignored for the current transaction.
- A requester may re-request in the cycle after its gnt (write) or rvalid (read). It is then arbitrated normally, so alternation is guaranteed under continuous contention.
- Reset while in ISSUE/WAIT/RESP aborts the transaction: no gnt/rvalid is produced, outputs go to reset values on the next edge, and last_gnt returns to 1.
- Width rules: no address alignment or sub-word extraction is done. Address and mask pass through; the requester handles lane selection.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0, stat_gnt1 (32-bit), counting grants per port.
  - Adds stat_stall (32-bit), counting cycles in which a port has req=1 but the arbiter is not in IDLE or the other port won.
  - All three clear on reset and wrap at 2^32 without saturation.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Port 0 write, addr=0x1000, wdata=0x1122334455667788, mask=0x0F, req at cycle T -> mem_en/mem_we=1 with those values and gnt0=1 at T+1; busy low at T+2.
- Port 1 read, addr=0x2008, RD_LAT=2, memory returns 0xDEADBEEFCAFEF00D -> gnt1 at T+1, rvalid1 at T+4, rdata=0xDEADBEEFCAFEF00D, mem_mask=0xFF.
- req0 and req1 both held continuously after reset (reads) -> gnt order 0,1,0,1; stat_gnt0=stat_gnt1=2 after 4 grants with ARB_STATS_EN.
- Reset asserted during WAIT of a port 0 read -> no rvalid0 ever pulses; the next req1 after reset is granted normally.
- req1 pulsed for 1 cycle while a port 0 read is in WAIT -> no port 1 transaction is issued, and mem_en pulses only once.
- RD_LAT=1 build, port 0 read -> rvalid0 at T+3 with correct data.
